// File: rtl/score_overlay_pkg.sv
// Shared types and constants for the score overlay: converter states, BCD nibble type,
// the 8x8 digit font and the shift-add-3 helper.
package score_overlay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_e;

  typedef logic [3:0] bcd_nibble_t;

  localparam int FONT_ROWS = 8;
  localparam int FONT_COLS = 8;

  // One 64-bit glyph per digit; row 0 is the top byte, bit 7 of each byte is the leftmost pixel.
  localparam logic [0:9][63:0] FONT = {
    64'h3C666E7666663C00,
    64'h1838181818187E00,
    64'h3C66060C30607E00,
    64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00,
    64'h7E607C0606663C00,
    64'h3C607C6666663C00,
    64'h7E060C1830303000,
    64'h3C66663C66663C00,
    64'h3C66663E060C3800
  };

  function automatic bcd_nibble_t add3_if_ge5(input bcd_nibble_t n);
    return (n >= 4'd5) ? bcd_nibble_t'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// done is high during the COMMIT cycle, while bcd holds the finished result.
module bin2bcd_seq #(
  parameter int W_BIN    = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_BIN-1:0]      bin,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  busy,
  output logic                  done
);
  import score_overlay_pkg::*;

  localparam int CNT_W = $clog2(W_BIN + 1);

  conv_state_e           state_q, state_d;
  logic [W_BIN-1:0]      bin_q, bin_d;
  logic [4*N_DIGITS-1:0] acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
    assign acc_adj[4*gi +: 4] = add3_if_ge5(acc_q[4*gi +: 4]);
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bin_d   = bin;
        acc_d   = '0;
        cnt_d   = CNT_W'(W_BIN);
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = {acc_adj[4*N_DIGITS-2:0], bin_q[W_BIN-1]};
        bin_d = {bin_q[W_BIN-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bcd  = acc_q;
  assign busy = busy_q;
  assign done = (state_q == COMMIT);

endmodule

// File: rtl/score_overlay.sv
// Pixel-pipeline stage that overlays the score as left-aligned decimal digits.
// Digits are refreshed once per frame on the vsync falling edge; all outputs are registered once.
module score_overlay #(
  parameter int          DIGITS     = 5,
  parameter int          X0         = 280,
  parameter int          Y0         = 40,
  parameter int          SCALE_LOG2 = 1,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_blank_n,
  input  logic        in_sync_n,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_blank_n,
  output logic        out_sync_n,
  output logic        busy
);
  import score_overlay_pkg::*;

  localparam int CELL_LOG2 = 3 + SCALE_LOG2;
  localparam int CELL      = 1 << CELL_LOG2;
  localparam int LEAD_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((X0 + DIGITS * CELL > 640) || (Y0 + CELL > 440)) begin : g_field_check
    $error("score_overlay: digit field does not fit inside 640x440");
  end

  logic                  in_vs_q, in_vs_d;
  logic                  hs_q, hs_d;
  logic                  blank_q, blank_d;
  logic                  sync_q, sync_d;
  logic [23:0]           rgb_q, rgb_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [LEAD_W-1:0]     lead_q, lead_d;

  logic                  start;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic                  conv_busy;
  logic                  conv_done;
  logic [LEAD_W-1:0]     lead_calc;

  assign start = in_vs_q & ~in_vs;

  bin2bcd_seq #(
    .W_BIN    (16),
    .N_DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (reset),
    .start (start),
    .bin   (score),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .done  (conv_done)
  );

  always_comb begin
    lead_calc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (conv_bcd[4*i +: 4] != 4'd0) lead_calc = LEAD_W'(i);
    end
  end

  bcd_nibble_t digit_arr [DIGITS];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
    assign digit_arr[gi] = disp_q[4*gi +: 4];
  end

  logic [10:0]       col, row, rel_x, rel_y, field_end;
  logic [LEAD_W-1:0] cell_idx, slot;
  logic [2:0]        gcol, grow;
  logic [5:0]        row_sh;
  bcd_nibble_t       digit;
  logic [7:0]        row_bits;
  logic              in_x, in_y, fg;
  logic              unused_hcount_lsb;

  assign unused_hcount_lsb = hcount[0];

  // Drawn width grows with the leading-digit index; cells are addressed from the left edge.
  always_comb begin
    col       = {1'b0, hcount[10:1]};
    row       = {1'b0, vcount};
    rel_x     = col - 11'(X0);
    rel_y     = row - 11'(Y0);
    field_end = (11'(lead_q) + 11'd1) << CELL_LOG2;
    in_x      = (col >= 11'(X0)) && (rel_x < field_end);
    in_y      = (row >= 11'(Y0)) && (rel_y < 11'(CELL));
    cell_idx  = LEAD_W'(rel_x >> CELL_LOG2);
    slot      = lead_q - cell_idx;
    digit     = digit_arr[slot];
    gcol      = 3'(rel_x >> SCALE_LOG2);
    grow      = 3'(rel_y >> SCALE_LOG2);
    row_sh    = {3'd7 - grow, 3'b000};
    row_bits  = FONT[digit][row_sh +: 8];
    fg        = in_x && in_y && row_bits[3'd7 - gcol];
  end

  always_comb begin
    in_vs_d = in_vs;
    hs_d    = in_hs;
    blank_d = in_blank_n;
    sync_d  = in_sync_n;
    disp_d  = disp_q;
    lead_d  = lead_q;
    if (conv_done) begin
      disp_d = conv_bcd;
      lead_d = lead_calc;
    end
    rgb_d = 24'h0;
    if (in_blank_n) rgb_d = fg ? FG_RGB : {in_r, in_g, in_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_vs_q <= 1'b1;
      hs_q    <= 1'b1;
      blank_q <= 1'b0;
      sync_q  <= 1'b0;
      rgb_q   <= 24'h0;
      disp_q  <= '0;
      lead_q  <= '0;
    end else begin
      in_vs_q <= in_vs_d;
      hs_q    <= hs_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
      rgb_q   <= rgb_d;
      disp_q  <= disp_d;
      lead_q  <= lead_d;
    end
  end

  assign out_r       = rgb_q[23:16];
  assign out_g       = rgb_q[15:8];
  assign out_b       = rgb_q[7:0];
  assign out_hs      = hs_q;
  assign out_vs      = in_vs_q;
  assign out_blank_n = blank_q;
  assign out_sync_n  = sync_q;
  assign busy        = conv_busy;

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: conversion timing, digit rendering, blanking and sync delay.
module tb_score_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] score;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_hs, in_vs, in_blank_n, in_sync_n;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_hs, out_vs, out_blank_n, out_sync_n;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] font_ref [10] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00,
    64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
    64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
    64'h3C66663E060C3800
  };

  always #10 clk = ~clk;

  score_overlay dut (
    .clk        (clk),
    .reset      (reset),
    .score      (score),
    .hcount     (hcount),
    .vcount     (vcount),
    .in_r       (in_r),
    .in_g       (in_g),
    .in_b       (in_b),
    .in_hs      (in_hs),
    .in_vs      (in_vs),
    .in_blank_n (in_blank_n),
    .in_sync_n  (in_sync_n),
    .out_r      (out_r),
    .out_g      (out_g),
    .out_b      (out_b),
    .out_hs     (out_hs),
    .out_vs     (out_vs),
    .out_blank_n(out_blank_n),
    .out_sync_n (out_sync_n),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int col, input int line);
    hcount     = 11'(col * 2 + (col & 1));
    vcount     = 10'(line);
    in_r       = 8'h10;
    in_g       = 8'h20;
    in_b       = 8'h30;
    in_blank_n = 1'b1;
  endtask

  // Reference picture: n digits (right-aligned BCD in d) drawn left-aligned from column 280, 16x16 cells.
  function automatic bit exp_fg(input int col, input int line, input logic [19:0] d, input int n);
    int          k, gx, gy;
    logic [3:0]  dig;
    logic [63:0] g;
    logic [7:0]  r;
    if (line < 40 || line > 55 || col < 280 || col >= 280 + 16 * n) return 1'b0;
    k   = (col - 280) / 16;
    dig = d[4 * (n - 1 - k) +: 4];
    g   = font_ref[dig];
    gx  = ((col - 280) % 16) / 2;
    gy  = (line - 40) / 2;
    r   = g[8 * (7 - gy) +: 8];
    return r[7 - gx];
  endfunction

  task automatic scan(input string tag, input logic [19:0] d, input int n);
    logic [95:0] obs, exp, bad;
    for (int line = 38; line <= 57; line++) begin
      obs = '0;
      exp = '0;
      bad = '0;
      for (int i = 0; i < 96; i++) begin
        set_pix(276 + i, line);
        tick;
        if ({out_r, out_g, out_b} === 24'hFFFFFF) obs[i] = 1'b1;
        else if ({out_r, out_g, out_b} !== 24'h102030) bad[i] = 1'b1;
        exp[i] = exp_fg(276 + i, line, d, n);
      end
      chk($sformatf("%s_line%0d_fg", tag, line), obs, exp);
      chk($sformatf("%s_line%0d_bg", tag, line), bad, 96'h0);
    end
    $display("scan %s done (%0d digits)", tag, n);
  endtask

  task automatic convert(input logic [15:0] s);
    score = s;
    in_vs = 1'b0;
    repeat (4) tick;
    in_vs = 1'b1;
    repeat (30) tick;
    chk("idle_after_convert", busy, 1'b0);
  endtask

  initial begin
    int          busy_cnt, first_busy, first_fg, p;
    logic [5:0]  pat;
    logic [27:0] prev_v, cur_v;

    reset = 1'b0;
    score = 16'd0;
    in_hs = 1'b1; in_vs = 1'b1; in_sync_n = 1'b1;
    set_pix(284, 40);
    repeat (3) tick;
    chk("reset_outputs", {out_r, out_g, out_b, out_hs, out_vs, out_blank_n, out_sync_n, busy},
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    reset = 1'b1;
    pat   = 6'b101100;
    for (int i = 0; i < 6; i++) begin
      in_blank_n = pat[i];
      tick;
      chk($sformatf("blank_mirror_%0d", i), out_blank_n, pat[i]);
    end
    scan("zero_after_reset", 20'h00000, 1);

    // 1234: busy must rise one cycle after the edge and stay high for 17 cycles.
    score = 16'd1234;
    in_vs = 1'b0;
    busy_cnt = 0; first_busy = -1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = i;
      end
      if (i == 3) in_vs = 1'b1;
    end
    chk("busy_cycles_1234", busy_cnt, 17);
    chk("busy_first_1234", first_busy, 1);
    scan("s1234", 20'h01234, 4);

    convert(16'd65535);
    scan("s65535", 20'h65535, 5);
    convert(16'd0);
    scan("s0", 20'h00000, 1);

    convert(16'd99);
    score = 16'd100;
    scan("still99", 20'h00099, 2);
    // Column 316 line 40 is lit only by the third digit of "100".
    set_pix(316, 40);
    in_vs = 1'b0;
    first_fg = -1;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (i == 3) in_vs = 1'b1;
      if (first_fg < 0 && {out_r, out_g, out_b} === 24'hFFFFFF) first_fg = i;
    end
    chk("latency_100", first_fg, 19);
    scan("s100", 20'h00100, 3);

    score = 16'd4321;
    in_vs = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (busy === 1'b1) busy_cnt++;
      if (i == 1) score = 16'd777;
      if (i == 2) in_vs = 1'b1;
      if (i == 4) in_vs = 1'b0;
      if (i == 8) in_vs = 1'b1;
    end
    chk("busy_cycles_double_edge", busy_cnt, 17);
    scan("s4321", 20'h04321, 4);

    score = 16'd65535;
    in_vs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 3) in_vs = 1'b1;
    end
    chk("busy_before_reset", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("busy_async_reset", busy, 1'b0);
    chk("outputs_async_reset", {out_r, out_g, out_b, out_hs, out_vs, out_blank_n, out_sync_n},
        {24'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    repeat (2) tick;
    reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("no_resume_after_reset", busy_cnt, 0);
    scan("zero_after_midreset", 20'h00000, 1);

    set_pix(284, 40);
    tick;
    chk("fg_visible", {out_r, out_g, out_b}, 24'hFFFFFF);
    in_blank_n = 1'b0;
    tick;
    chk("blank_in_field", {out_r, out_g, out_b}, 24'h0);
    set_pix(500, 40);
    tick;
    chk("bg_passthrough", {out_r, out_g, out_b}, 24'h102030);
    in_blank_n = 1'b0;
    tick;
    chk("blank_outside_field", {out_r, out_g, out_b}, 24'h0);

    hcount = 11'd0;
    vcount = 10'd0;
    prev_v = '0;
    for (int i = 0; i < 400; i++) begin
      p          = i % 100;
      in_hs      = (p >= 12);
      in_vs      = !(i >= 200 && i < 206);
      in_blank_n = (p >= 20 && p < 90);
      in_sync_n  = (i % 7) != 0;
      in_r       = 8'(i);
      in_g       = 8'(i * 3);
      in_b       = 8'(i * 7);
      cur_v      = {in_blank_n ? {in_r, in_g, in_b} : 24'h0, in_hs, in_vs, in_blank_n, in_sync_n};
      #1;
      if (i > 0)
        chk($sformatf("sync_hold_%0d", i),
            {out_r, out_g, out_b, out_hs, out_vs, out_blank_n, out_sync_n}, prev_v);
      tick;
      chk($sformatf("sync_delay_%0d", i),
          {out_r, out_g, out_b, out_hs, out_vs, out_blank_n, out_sync_n}, cur_v);
      prev_v = cur_v;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
